hbuf_pg_arbiter: RTL

HBUF_PG_ARBITER -- requirements
Module: hbuf_pg_arbiter

---
 rtl/hbuf_pg_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hbuf_pg_arbiter.sv
// ============================================================================
//  Module      : hbuf_pg_arbiter
//  Description : Arbitrates page requests from N_REQ hbuf_ctrl requesters onto
//                a single DDR3 page-engine port. One transfer is in flight at
//                a time: grant in IDLE, hold pg_req_o in REQ until the engine
//                acks, then hold the requester's ack in ACK until it drops
//                its request. Grant selection is round-robin (P_MODE=0) or
//                fixed lowest-index priority (P_MODE=1).
//  Ports       : clk, rst (sync, active-low)
//                req_i/optype_i/addr_i  - per-requester page request inputs
//                ack_o                  - per-requester ack (one-hot or zero)
//                pg_req_o/pg_ack_i      - page-engine handshake
//                pg_optype_o/pg_addr_o/pg_src_o - latched grant information
//                busy_o                 - high whenever not in IDLE
//                n_xfers_o              - completed transfer counter (wraps)
//                timeout_err_o          - sticky REQ-phase timeout flag
//                proto_err_o            - sticky protocol-violation flag
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hbuf_pg_arbiter #(
    parameter int N_REQ        = 4,
    parameter int P_ADDR_WIDTH = 28,
    parameter int P_MODE       = 0,
    parameter int P_TIMEOUT    = 0,
    localparam int P_SRC_WIDTH = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0]              optype_i,
    input  logic [N_REQ*P_ADDR_WIDTH-1:0] addr_i,
    output logic [N_REQ-1:0]              ack_o,
    output logic                          pg_req_o,
    input  logic                          pg_ack_i,
    output logic                          pg_optype_o,
    output logic [P_ADDR_WIDTH-1:0]       pg_addr_o,
    output logic [P_SRC_WIDTH-1:0]        pg_src_o,
    output logic                          busy_o,
    output logic [31:0]                   n_xfers_o,
    output logic                          timeout_err_o,
    output logic                          proto_err_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_ack  = 2'd2;

    localparam logic [P_SRC_WIDTH-1:0] c_src_one  = P_SRC_WIDTH'(1);
    localparam logic [P_SRC_WIDTH-1:0] c_src_last = P_SRC_WIDTH'(N_REQ - 1);
    localparam logic [N_REQ-1:0]       c_ack_lsb  = N_REQ'(1);

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [N_REQ-1:0]        r_ack;
    logic                    r_pg_req;
    logic                    r_optype;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_SRC_WIDTH-1:0]  r_src;
    logic                    r_busy;
    logic [31:0]             r_n_xfers;
    logic                    r_proto_err;

    logic                    w_grant_vld;
    logic [P_SRC_WIDTH-1:0]  w_grant_idx;
    logic                    w_timeout_err;
    logic [P_ADDR_WIDTH-1:0] w_addr_arr [N_REQ];

    // ------------------------------------------------------------------
    // Split the flat address bus into one word per requester
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_addr_unpack
            assign w_addr_arr[k] = addr_i[k*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    generate
        if (P_MODE == 0) begin : g_rr
            logic [P_SRC_WIDTH-1:0] r_rr_ptr;

            // Walk upward from the pointer, wrapping at N_REQ, and take the
            // first asserted request encountered.
            always_comb begin
                logic [P_SRC_WIDTH-1:0] v_idx;
                logic                   v_found;
                w_grant_idx = '0;
                v_found     = 1'b0;
                v_idx       = r_rr_ptr;
                for (int k = 0; k < N_REQ; k++) begin
                    if (!v_found && req_i[v_idx]) begin
                        w_grant_idx = v_idx;
                        v_found     = 1'b1;
                    end
                    v_idx = (v_idx == c_src_last) ? '0 : (v_idx + c_src_one);
                end
                w_grant_vld = v_found;
            end

            // The pointer only moves when a grant is actually issued, so a
            // requester that keeps asserting cannot starve its neighbours.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rr_ptr <= '0;
                end else if (r_state == c_st_idle && w_grant_vld) begin
                    r_rr_ptr <= (w_grant_idx == c_src_last) ? '0
                                                            : (w_grant_idx + c_src_one);
                end
            end
        end else begin : g_fixed
            // Scan from the top index down so the lowest asserted index is
            // the last one written and therefore wins.
            always_comb begin
                logic [P_SRC_WIDTH-1:0] v_idx;
                w_grant_idx = '0;
                v_idx       = c_src_last;
                for (int k = 0; k < N_REQ; k++) begin
                    if (req_i[v_idx]) begin
                        w_grant_idx = v_idx;
                    end
                    v_idx = v_idx - c_src_one;
                end
                w_grant_vld = |req_i;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Main transfer state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_ack       <= '0;
            r_pg_req    <= 1'b0;
            r_optype    <= 1'b0;
            r_addr      <= '0;
            r_src       <= '0;
            r_busy      <= 1'b0;
            r_n_xfers   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // An engine ack while idle is meaningless and is ignored.
                    if (w_grant_vld) begin
                        r_state  <= c_st_req;
                        r_src    <= w_grant_idx;
                        r_addr   <= w_addr_arr[w_grant_idx];
                        r_optype <= optype_i[w_grant_idx];
                        r_pg_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end

                c_st_req: begin
                    // The granted requester must hold its request until it
                    // is acked; flag a drop but let the transfer finish.
                    if (!req_i[r_src]) begin
                        r_proto_err <= 1'b1;
                    end
                    if (pg_ack_i) begin
                        r_state  <= c_st_ack;
                        r_pg_req <= 1'b0;
                        r_ack    <= c_ack_lsb << r_src;
                    end
                end

                c_st_ack: begin
                    // Leave only once both sides of the handshake have
                    // released, so neither can see a stale level next grant.
                    if (!req_i[r_src] && !pg_ack_i) begin
                        r_state   <= c_st_idle;
                        r_ack     <= '0;
                        r_busy    <= 1'b0;
                        r_n_xfers <= r_n_xfers + 32'd1;
                    end
                end

                default: begin
                    r_state  <= c_st_idle;
                    r_ack    <= '0;
                    r_pg_req <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // REQ-phase timeout monitor (reporting only, never aborts a transfer)
    // ------------------------------------------------------------------
    generate
        if (P_TIMEOUT > 0) begin : g_tmo
            localparam int c_tmo_w = ($clog2(P_TIMEOUT + 1) > 1) ? $clog2(P_TIMEOUT + 1) : 1;
            localparam logic [c_tmo_w-1:0] c_tmo_lim    = c_tmo_w'(P_TIMEOUT);
            localparam logic [c_tmo_w-1:0] c_tmo_lim_m1 = c_tmo_w'(P_TIMEOUT - 1);
            localparam logic [c_tmo_w-1:0] c_tmo_one    = c_tmo_w'(1);

            logic [c_tmo_w-1:0] r_tmo_cnt;
            logic               r_timeout_err;

            // The count saturates at the limit so a very long wait cannot
            // wrap it back into range.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_tmo_cnt     <= '0;
                    r_timeout_err <= 1'b0;
                end else if (r_state == c_st_idle) begin
                    if (w_grant_vld) begin
                        r_tmo_cnt <= '0;
                    end
                end else if (r_state == c_st_req) begin
                    if (r_tmo_cnt != c_tmo_lim) begin
                        r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
                    end
                    if (r_tmo_cnt == c_tmo_lim_m1) begin
                        r_timeout_err <= 1'b1;
                    end
                end
            end

            assign w_timeout_err = r_timeout_err;
        end else begin : g_no_tmo
            assign w_timeout_err = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack_o         = r_ack;
    assign pg_req_o      = r_pg_req;
    assign pg_optype_o   = r_optype;
    assign pg_addr_o     = r_addr;
    assign pg_src_o      = r_src;
    assign busy_o        = r_busy;
    assign n_xfers_o     = r_n_xfers;
    assign timeout_err_o = w_timeout_err;
    assign proto_err_o   = r_proto_err;

endmodule

`default_nettype wire
